// File: rtl/munoc_fni_request_scheduler.sv
// munoc_fni_request_scheduler
//   Grants one of three header/data requesters (AR, AW, W) onto a single
//   shared forward link. W wins whenever it has a matching AW already
//   forwarded. Once a W burst has started it owns the link until w_last.
//   AR and AW alternate round-robin. AW grants are throttled by the number
//   of write responses still outstanding.
//
// Ports
//   clk_network        single rising-edge clock
//   rstpp_network      synchronous active-high reset
//   comm_disable       blocks new AR/AW grants (an open W burst still drains)
//   ar_valid/ar_ready  AR header requester
//   aw_valid/aw_ready  AW header requester
//   w_valid/w_last/w_ready  W data requester
//   fwd_valid/fwd_sel/fwd_ready  shared forward link (sel 0=AR, 1=AW, 2=W)
//   b_done             one-cycle pulse per returned write response
//   write_outstanding  AW headers sent without a returned response
//   aw_pending         AW headers whose W burst has not finished yet
//   busy               open burst or any counter non-zero
//   protocol_error     sticky: b_done arrived with nothing outstanding
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | arbitrating: W first, then round-robin between AR and AW
// WBURST  | W burst open; only W may use the link until w_last

module munoc_fni_request_scheduler #(
  parameter int MAX_OUTSTANDING_WRITE = 4,
  parameter int BW_OUTSTANDING        = 3
) (
  input  logic                      clk_network,
  input  logic                      rstpp_network,
  input  logic                      comm_disable,
  input  logic                      ar_valid,
  output logic                      ar_ready,
  input  logic                      aw_valid,
  output logic                      aw_ready,
  input  logic                      w_valid,
  input  logic                      w_last,
  output logic                      w_ready,
  output logic                      fwd_valid,
  output logic [1:0]                fwd_sel,
  input  logic                      fwd_ready,
  input  logic                      b_done,
  output logic [BW_OUTSTANDING-1:0] write_outstanding,
  output logic [BW_OUTSTANDING-1:0] aw_pending,
  output logic                      busy,
  output logic                      protocol_error
);

  localparam logic [1:0] SEL_AR = 2'd0;
  localparam logic [1:0] SEL_AW = 2'd1;
  localparam logic [1:0] SEL_W  = 2'd2;
  localparam logic [BW_OUTSTANDING-1:0] MAX_WR = BW_OUTSTANDING'(MAX_OUTSTANDING_WRITE);

  typedef enum logic {ST_IDLE, ST_WBURST} state_t;

  state_t     state;
  logic       rr_aw;       // 1 = AW favoured in the next AR/AW tie
  logic       hold_valid;  // last cycle offered something that was not taken
  logic [1:0] hold_sel;

  logic elig_ar, elig_aw, elig_w, hold_ok;
  logic sel_valid;
  logic [1:0] sel;
  logic xfer, ar_xfer, aw_xfer, w_xfer, w_last_xfer, b_ok;

  always_comb begin
    elig_ar = ar_valid && !comm_disable;
    elig_aw = aw_valid && !comm_disable && (write_outstanding < MAX_WR);
    elig_w  = w_valid && (aw_pending != '0);

    // A stalled offer keeps the link so the downstream sees a stable request.
    hold_ok = hold_valid &&
              (((hold_sel == SEL_AR) && elig_ar) ||
               ((hold_sel == SEL_AW) && elig_aw) ||
               ((hold_sel == SEL_W)  && elig_w));

    sel_valid = 1'b0;
    sel       = SEL_AR;
    if (state == ST_WBURST) begin
      sel_valid = w_valid;
      if (w_valid) sel = SEL_W;
    end else if (hold_ok) begin
      sel_valid = 1'b1;
      sel       = hold_sel;
    end else if (elig_w) begin
      sel_valid = 1'b1;
      sel       = SEL_W;
    end else if (elig_ar && elig_aw) begin
      sel_valid = 1'b1;
      sel       = rr_aw ? SEL_AW : SEL_AR;
    end else if (elig_ar) begin
      sel_valid = 1'b1;
      sel       = SEL_AR;
    end else if (elig_aw) begin
      sel_valid = 1'b1;
      sel       = SEL_AW;
    end
  end

  assign fwd_valid = sel_valid;
  assign fwd_sel   = sel;
  assign xfer      = sel_valid && fwd_ready;
  assign ar_xfer   = xfer && (sel == SEL_AR);
  assign aw_xfer   = xfer && (sel == SEL_AW);
  assign w_xfer    = xfer && (sel == SEL_W);
  assign w_last_xfer = w_xfer && w_last;
  assign b_ok      = b_done && (write_outstanding != '0);

  assign ar_ready = ar_xfer;
  assign aw_ready = aw_xfer;
  assign w_ready  = w_xfer;
  assign busy     = (state == ST_WBURST) || (write_outstanding != '0) || (aw_pending != '0);

  always_ff @(posedge clk_network) begin
    if (rstpp_network) begin
      state             <= ST_IDLE;
      rr_aw             <= 1'b0;
      hold_valid        <= 1'b0;
      hold_sel          <= SEL_AR;
      write_outstanding <= '0;
      aw_pending        <= '0;
      protocol_error    <= 1'b0;
    end else begin
      hold_valid <= sel_valid && !fwd_ready;
      hold_sel   <= sel;

      case (state)
        ST_IDLE:   if (w_xfer && !w_last) state <= ST_WBURST;
        ST_WBURST: if (w_last_xfer)       state <= ST_IDLE;
        default:                          state <= ST_IDLE;
      endcase

      if (ar_xfer)      rr_aw <= 1'b1;
      else if (aw_xfer) rr_aw <= 1'b0;

      // AW transfer and the last W beat can never share a cycle.
      if (aw_xfer)          aw_pending <= aw_pending + 1'b1;
      else if (w_last_xfer) aw_pending <= aw_pending - 1'b1;

      if (aw_xfer && !b_ok)      write_outstanding <= write_outstanding + 1'b1;
      else if (!aw_xfer && b_ok) write_outstanding <= write_outstanding - 1'b1;

      if (b_done && (write_outstanding == '0)) protocol_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_munoc_fni_request_scheduler.sv
module tb_munoc_fni_request_scheduler;

  localparam int MAXW = 4;
  localparam int BW   = 3;

  logic          clk_network = 1'b0;
  logic          rstpp_network;
  logic          comm_disable;
  logic          ar_valid, ar_ready;
  logic          aw_valid, aw_ready;
  logic          w_valid, w_last, w_ready;
  logic          fwd_valid;
  logic [1:0]    fwd_sel;
  logic          fwd_ready;
  logic          b_done;
  logic [BW-1:0] write_outstanding;
  logic [BW-1:0] aw_pending;
  logic          busy;
  logic          protocol_error;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] exp_sel_a [10] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0};

  always #5 clk_network = ~clk_network;

  munoc_fni_request_scheduler #(
    .MAX_OUTSTANDING_WRITE (MAXW),
    .BW_OUTSTANDING        (BW)
  ) dut (
    .clk_network       (clk_network),
    .rstpp_network     (rstpp_network),
    .comm_disable      (comm_disable),
    .ar_valid          (ar_valid),
    .ar_ready          (ar_ready),
    .aw_valid          (aw_valid),
    .aw_ready          (aw_ready),
    .w_valid           (w_valid),
    .w_last            (w_last),
    .w_ready           (w_ready),
    .fwd_valid         (fwd_valid),
    .fwd_sel           (fwd_sel),
    .fwd_ready         (fwd_ready),
    .b_done            (b_done),
    .write_outstanding (write_outstanding),
    .aw_pending        (aw_pending),
    .busy              (busy),
    .protocol_error    (protocol_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk_network);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic idle_inputs;
    comm_disable = 1'b0;
    ar_valid     = 1'b0;
    aw_valid     = 1'b0;
    w_valid      = 1'b0;
    w_last       = 1'b0;
    fwd_ready    = 1'b0;
    b_done       = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rstpp_network = 1'b1;
    tick();
    tick();
    rstpp_network = 1'b0;
    settle();
  endtask

  initial begin
    rstpp_network = 1'b1;
    idle_inputs();

    // reset state
    do_reset();
    check("rst_fwd_valid", 32'(fwd_valid), 0);
    check("rst_fwd_sel",   32'(fwd_sel), 0);
    check("rst_readies",   32'({ar_ready, aw_ready, w_ready}), 0);
    check("rst_busy",      32'(busy), 0);
    check("rst_wr_out",    32'(write_outstanding), 0);
    check("rst_aw_pend",   32'(aw_pending), 0);
    check("rst_perr",      32'(protocol_error), 0);

    // AR/AW alternate, AW stops at the outstanding limit
    ar_valid  = 1'b1;
    aw_valid  = 1'b1;
    fwd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      settle();
      check("rr_valid",    32'(fwd_valid), 1);
      check("rr_sel",      32'(fwd_sel), 32'(exp_sel_a[i]));
      check("rr_aw_ready", 32'(aw_ready), 32'(exp_sel_a[i] == 2'd1));
      tick();
    end
    ar_valid = 1'b0;
    settle();
    check("rr_wr_out", 32'(write_outstanding), 4);
    check("rr_aw_pend", 32'(aw_pending), 4);
    check("limit_aw_blocked", 32'(fwd_valid), 0);

    // b_done frees a slot; AW + b_done together leave the count unchanged
    b_done = 1'b1;
    tick();
    b_done = 1'b0;
    settle();
    check("bdone_wr_out", 32'(write_outstanding), 3);
    check("bdone_aw_valid", 32'(fwd_valid), 1);
    check("bdone_aw_sel", 32'(fwd_sel), 1);
    b_done = 1'b1;
    tick();
    b_done   = 1'b0;
    aw_valid = 1'b0;
    settle();
    check("aw_and_bdone_wr_out", 32'(write_outstanding), 3);
    check("aw_and_bdone_pend", 32'(aw_pending), 5);

    // 4-beat W burst is not interleaved with AR
    do_reset();
    aw_valid  = 1'b1;
    fwd_ready = 1'b1;
    settle();
    check("burst_aw_sel", 32'(fwd_sel), 1);
    tick();
    aw_valid = 1'b0;
    ar_valid = 1'b1;
    w_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_last = (i == 3);
      settle();
      check("burst_sel", 32'(fwd_sel), 2);
      check("burst_w_ready", 32'(w_ready), 1);
      check("burst_ar_ready", 32'(ar_ready), 0);
      tick();
    end
    w_valid = 1'b0;
    w_last  = 1'b0;
    settle();
    check("burst_pend_after", 32'(aw_pending), 0);
    check("burst_ar_next", 32'(fwd_sel), 0);
    check("burst_ar_ready", 32'(ar_ready), 1);
    check("burst_busy", 32'(busy), 1);
    tick();
    ar_valid = 1'b0;

    // W waits for an AW
    do_reset();
    w_valid   = 1'b1;
    w_last    = 1'b1;
    fwd_ready = 1'b1;
    settle();
    check("w_no_aw_valid", 32'(fwd_valid), 0);
    check("w_no_aw_ready", 32'(w_ready), 0);
    tick();
    settle();
    check("w_no_aw_valid2", 32'(fwd_valid), 0);
    aw_valid = 1'b1;
    settle();
    check("w_aw_first", 32'(fwd_sel), 1);
    tick();
    aw_valid = 1'b0;
    settle();
    check("w_after_aw_sel", 32'(fwd_sel), 2);
    check("w_after_aw_ready", 32'(w_ready), 1);
    tick();
    w_valid = 1'b0;
    settle();
    check("w_after_pend", 32'(aw_pending), 0);

    // comm_disable mid-burst: burst drains, AR waits until release
    do_reset();
    aw_valid  = 1'b1;
    fwd_ready = 1'b1;
    tick();
    aw_valid = 1'b0;
    ar_valid = 1'b1;
    w_valid  = 1'b1;
    w_last   = 1'b0;
    settle();
    check("cd_beat1", 32'(fwd_sel), 2);
    tick();
    comm_disable = 1'b1;
    settle();
    check("cd_beat2", 32'(fwd_sel), 2);
    tick();
    settle();
    check("cd_beat3_valid", 32'(fwd_valid), 1);
    check("cd_beat3_sel", 32'(fwd_sel), 2);
    tick();
    w_last = 1'b1;
    settle();
    check("cd_beat4", 32'(w_ready), 1);
    tick();
    w_valid = 1'b0;
    w_last  = 1'b0;
    settle();
    check("cd_ar_blocked", 32'(fwd_valid), 0);
    check("cd_ar_ready_blocked", 32'(ar_ready), 0);
    comm_disable = 1'b0;
    settle();
    check("cd_release_valid", 32'(fwd_valid), 1);
    check("cd_release_sel", 32'(fwd_sel), 0);
    check("cd_release_ar_ready", 32'(ar_ready), 1);
    tick();
    ar_valid = 1'b0;

    // stalled AW stays selected when AR shows up
    do_reset();
    aw_valid = 1'b1;
    settle();
    check("stall_aw_sel", 32'(fwd_sel), 1);
    tick();
    ar_valid = 1'b1;
    settle();
    check("stall_hold_sel", 32'(fwd_sel), 1);
    fwd_ready = 1'b1;
    tick();
    aw_valid = 1'b0;
    settle();
    check("stall_then_ar", 32'(fwd_sel), 0);
    tick();
    ar_valid = 1'b0;

    // protocol error and reset mid-burst
    do_reset();
    b_done = 1'b1;
    tick();
    b_done = 1'b0;
    settle();
    check("perr_set", 32'(protocol_error), 1);
    check("perr_wr_out", 32'(write_outstanding), 0);
    tick();
    tick();
    settle();
    check("perr_sticky", 32'(protocol_error), 1);
    fwd_ready = 1'b1;
    aw_valid  = 1'b1;
    tick();
    aw_valid = 1'b0;
    w_valid  = 1'b1;
    w_last   = 1'b0;
    settle();
    check("pre_rst_busy", 32'(busy), 1);
    tick();
    settle();
    check("pre_rst_wburst", 32'(fwd_valid), 1);
    rstpp_network = 1'b1;
    tick();
    rstpp_network = 1'b0;
    settle();
    check("mid_rst_fwd_valid", 32'(fwd_valid), 0);
    check("mid_rst_w_ready", 32'(w_ready), 0);
    check("mid_rst_wr_out", 32'(write_outstanding), 0);
    check("mid_rst_pend", 32'(aw_pending), 0);
    check("mid_rst_perr", 32'(protocol_error), 0);
    check("mid_rst_busy", 32'(busy), 0);
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
